// File: rtl/serial_adder_n.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry flop.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port (a - b with borrow on carry_o).
module serial_adder_n #(
    parameter int nb_bit = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic              sub_i,
`endif
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [nb_bit-1:0] sum_o,
    output logic              carry_o
);

    localparam int CW = $clog2(nb_bit + 1);
    localparam logic [CW-1:0] LAST = CW'(nb_bit - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [nb_bit-1:0] a_sh;
    logic [nb_bit-1:0] b_sh;
    logic [nb_bit-1:0] r_sh;
    logic              c;
    logic [CW-1:0]     cnt;
    logic              sub_q;

    logic              s;
    logic              c_nxt;
    logic [nb_bit-1:0] r_nxt;
    logic              load_sub;
    logic [nb_bit-1:0] load_b;

`ifdef SERIAL_ADDER_SUB_EN
    assign load_sub = sub_i;
`else
    assign load_sub = 1'b0;
`endif

    // Subtraction adds the one's complement of b with carry-in of one.
    assign load_b = load_sub ? ~b_i : b_i;

    // Full-adder slice on the current LSBs and next result-register value.
    always_comb begin
        s     = a_sh[0] ^ b_sh[0] ^ c;
        c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        r_nxt = r_sh >> 1;
        r_nxt[nb_bit-1] = s;
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sub_q   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sum_o   <= '0;
            carry_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= load_b;
                        r_sh   <= '0;
                        c      <= load_sub;
                        sub_q  <= load_sub;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nxt;
                    c    <= c_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state   <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        sum_o   <= r_nxt;
                        carry_o <= c_nxt ^ sub_q;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at nb_bit=4 and nb_bit=1.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       carry4;
    logic       sub4 = 1'b0;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;
    logic       sub1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.nb_bit(4)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub4),
`endif
        .a_i     (a4),
        .b_i     (b4),
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .carry_o (carry4)
    );

    serial_adder_n #(.nb_bit(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub1),
`endif
        .a_i     (a1),
        .b_i     (b1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .carry_o (carry1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4-bit operation: start for one cycle, 4 busy cycles, then done.
    task automatic run4(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic sb,
                        input int es, input int ec);
        a4 = a;
        b4 = b;
        sub4 = sb;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        a4 = ~a;
        b4 = ~b;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, busy4, 1);
            check({tag, "_nodone"}, done4, 0);
            step();
        end
        check({tag, "_done"}, done4, 1);
        check({tag, "_idle"}, busy4, 0);
        check({tag, "_sum"}, sum4, es);
        check({tag, "_carry"}, carry4, ec);
        step();
        check({tag, "_pulse"}, done4, 0);
        check({tag, "_hold"}, sum4, es);
    endtask

    task automatic run1(input string tag, input logic a, input logic b,
                        input int es, input int ec);
        a1 = a;
        b1 = b;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check({tag, "_busy"}, busy1, 1);
        check({tag, "_nodone"}, done1, 0);
        step();
        check({tag, "_done"}, done1, 1);
        check({tag, "_sum"}, sum1, es);
        check({tag, "_carry"}, carry1, ec);
        step();
        check({tag, "_pulse"}, done1, 0);
    endtask

    initial begin
        int t_done;
        int gap;

        step();
        step();
        check("rst_sum", sum4, 0);
        check("rst_carry", carry4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        rst = 1'b0;
        step();
        check("idle_busy", busy4, 0);

        run4("t1_5p3", 4'd5, 4'd3, 1'b0, 8, 0);
        check("t1_after_busy", busy4, 0);
        run4("t2_15p1", 4'd15, 4'd1, 1'b0, 0, 1);
        run4("t2_0p0", 4'd0, 4'd0, 1'b0, 0, 0);
        run4("t2_9p9", 4'd9, 4'd9, 1'b0, 2, 1);

        // Back-to-back with start held through DONE.
        a4 = 4'd7;
        b4 = 4'd9;
        start4 = 1'b1;
        step();
        a4 = 4'd2;
        b4 = 4'd2;
        t_done = -1;
        gap = -1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 5) begin
                check("t3_done1", done4, 1);
                check("t3_sum1", sum4, 0);
                check("t3_carry1", carry4, 1);
            end
            if (i == 6) begin
                start4 = 1'b0;
                check("t3_reaccept", busy4, 1);
                check("t3_hold_sum", sum4, 0);
                check("t3_hold_carry", carry4, 1);
            end
            if (done4) begin
                if (t_done >= 0 && gap < 0) gap = i - t_done;
                t_done = i;
            end
            if (i == 10) begin
                check("t3_sum2", sum4, 4);
                check("t3_carry2", carry4, 0);
            end
            step();
        end
        check("t3_gap", gap, 5);

        // Reset during the second SHIFT cycle aborts the operation.
        a4 = 4'd6;
        b4 = 4'd6;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_busy", busy4, 0);
        check("t4_done", done4, 0);
        check("t4_sum", sum4, 0);
        check("t4_carry", carry4, 0);
        t_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done4) t_done++;
            step();
        end
        check("t4_no_done", t_done, 0);
        run4("t4_1p2", 4'd1, 4'd2, 1'b0, 3, 0);

        run1("t5_00", 1'b0, 1'b0, 0, 0);
        run1("t5_01", 1'b0, 1'b1, 1, 0);
        run1("t5_10", 1'b1, 1'b0, 1, 0);
        run1("t5_11", 1'b1, 1'b1, 0, 1);

`ifdef SERIAL_ADDER_SUB_EN
        run4("t6_5m3", 4'd5, 4'd3, 1'b1, 2, 0);
        run4("t6_3m5", 4'd3, 4'd5, 1'b1, 14, 1);
        run4("t6_add", 4'd3, 4'd5, 1'b0, 8, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
